// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file for the pipelined core.
//
// Provides N_RD combinational read ports, an ALU writeback port (A: we3/wa3/wd3)
// and a load writeback port (B: we4/wa4/wd4). A per-register busy scoreboard
// marks registers whose load is still outstanding so decode can stall on them.
// Optional same-cycle write-to-read bypass (BYPASS) and optional PC aliasing of
// the top register (PC_EN) are selected by parameter.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-low reset
//   ra         N_RD packed read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd         N_RD packed read data,     port i = rd[i*WIDTH +: WIDTH] (comb)
//   rbusy      per-port "register has a pending load" flag (comb)
//   we3/wa3/wd3  write port A (ALU writeback); wins on an address collision
//   we4/wa4/wd4  write port B (load writeback); also clears busy[wa4]
//   busy_set/busy_addr  load issue: mark busy_addr pending
//   r15        PC+8 value returned for reads of the top register when PC_EN=1
//   pc_write   an enabled write targets the PC alias (comb)
//   wcollide   registered; high the cycle after A and B wrote the same address
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1,
  parameter int PC_EN  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   ra,
  output logic [N_RD*WIDTH-1:0]    rd,
  output logic [N_RD-1:0]          rbusy,
  input  logic                     we3,
  input  logic [ADDR_W-1:0]        wa3,
  input  logic [WIDTH-1:0]         wd3,
  input  logic                     we4,
  input  logic [ADDR_W-1:0]        wa4,
  input  logic [WIDTH-1:0]         wd4,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  input  logic [WIDTH-1:0]         r15,
  output logic                     pc_write,
  output logic                     wcollide
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = '1;
  localparam bit                BYP     = (BYPASS != 0);
  localparam bit                PC      = (PC_EN != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wcollide_q, wcollide_d;
  logic             wr3_arr, wr4_arr;

  // Writes aimed at the PC alias never reach the array; they only raise pc_write.
  assign wr3_arr = we3 && !(PC && (wa3 == PC_ADDR));
  assign wr4_arr = we4 && !(PC && (wa4 == PC_ADDR));

  assign pc_write   = PC && ((we3 && (wa3 == PC_ADDR)) || (we4 && (wa4 == PC_ADDR)));
  assign wcollide_d = we3 && we4 && (wa3 == wa4);
  assign wcollide   = wcollide_q;

  // Scoreboard next state: a clear from the returning load is applied first so
  // that a load issued to the same register in the same cycle leaves it busy.
  always_comb begin
    // NOTE: start from a full default so every bit is assigned on every path;
    // otherwise the tool infers a latch for the untouched bits.
    busy_d = busy_q;
    if (we4) busy_d[wa4] = 1'b0;
    if (busy_set && !(PC && (busy_addr == PC_ADDR))) busy_d[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the array is built from flops, not a RAM macro, because every
      // entry must read zero after reset; a RAM would not allow this clear.
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
      busy_q     <= '0;
      wcollide_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; with both ports on one address the
      // later statement (port A) is the one that lands, giving A priority.
      if (wr4_arr) mem_q[wa4] <= wd4;
      if (wr3_arr) mem_q[wa3] <= wd3;
      busy_q     <= busy_d;
      wcollide_q <= wcollide_d;
    end
  end

  // Read ports: PC alias, then port A bypass, then port B bypass, then storage.
  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              pc_hit, byp3, byp4;
    logic [WIDTH-1:0]  rd_word;

    assign addr    = ra[gi*ADDR_W +: ADDR_W];
    assign pc_hit  = PC && (addr == PC_ADDR);
    assign byp3    = BYP && we3 && (wa3 == addr);
    assign byp4    = BYP && we4 && (wa4 == addr);
    assign rd_word = pc_hit ? r15 :
                     byp3   ? wd3 :
                     byp4   ? wd4 : mem_q[addr];

    assign rd[gi*WIDTH +: WIDTH] = rd_word;
    // A load returning this cycle is forwarded by the bypass, so it no longer stalls.
    assign rbusy[gi] = !pc_hit && busy_q[addr] && !byp4;
  end

endmodule
